// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache block fills onto one pipelined main memory.
// Issues the winner's word reads, routes returning words, then pulses its tag write.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic              i_write_tag,
    output logic              d_write_tag,
    output logic              i_stall,
    output logic              d_stall,
    output logic              busy
);

    localparam int unsigned OB = $clog2(WORDS) + 1;
    localparam int unsigned CW = OB;
    localparam int unsigned BW = ADDR_W - OB;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;

    state_t          state, state_nx;
    side_t           grant, grant_nx;
    side_t           last_served, last_served_nx;
    logic [BW-1:0]   base, base_nx;
    logic [CW-1:0]   issue_cnt, issue_cnt_nx;
    logic [CW-1:0]   recv_cnt, recv_cnt_nx;

    // Offset bits of the miss addresses are never needed: fills are block aligned.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_miss_addr[OB-1:0], d_miss_addr[OB-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= SIDE_D;
            last_served <= SIDE_I;
            base        <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            last_served <= last_served_nx;
            base        <= base_nx;
            issue_cnt   <= issue_cnt_nx;
            recv_cnt    <= recv_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        grant_nx       = grant;
        last_served_nx = last_served;
        base_nx        = base;
        issue_cnt_nx   = issue_cnt;
        recv_cnt_nx    = recv_cnt;
        mem_enable     = 1'b0;
        mem_addr       = '0;
        fill_addr      = '0;
        i_fill_valid   = 1'b0;
        d_fill_valid   = 1'b0;
        i_write_tag    = 1'b0;
        d_write_tag    = 1'b0;

        case (state)
            IDLE: begin
                if (i_miss || d_miss) begin
                    // Ties alternate away from whoever was served last.
                    if (i_miss && d_miss) begin
                        grant_nx = (last_served == SIDE_I) ? SIDE_D : SIDE_I;
                    end else begin
                        grant_nx = d_miss ? SIDE_D : SIDE_I;
                    end
                    base_nx      = (grant_nx == SIDE_D) ? d_miss_addr[ADDR_W-1:OB]
                                                        : i_miss_addr[ADDR_W-1:OB];
                    issue_cnt_nx = '0;
                    recv_cnt_nx  = '0;
                    state_nx     = FILL;
                end
            end
            FILL: begin
                if (issue_cnt < CW'(WORDS)) begin
                    mem_enable   = 1'b1;
                    mem_addr     = {base, issue_cnt[OB-2:0], 1'b0};
                    issue_cnt_nx = issue_cnt + CW'(1);
                end
                if (mem_data_valid) begin
                    fill_addr = {base, recv_cnt[OB-2:0], 1'b0};
                    if (grant == SIDE_D) begin
                        d_fill_valid = 1'b1;
                    end else begin
                        i_fill_valid = 1'b1;
                    end
                    recv_cnt_nx = recv_cnt + CW'(1);
                    if (recv_cnt == CW'(WORDS - 1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // An abandoned miss keeps its data but never gets its tag written.
                d_write_tag    = (grant == SIDE_D) && d_miss;
                i_write_tag    = (grant == SIDE_I) && i_miss;
                last_served_nx = grant;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stalls are masked while reset is asserted so every output reads 0 in reset.
    assign i_stall = rst_n & i_miss & ~((state == DONE) & (grant == SIDE_I) & i_write_tag);
    assign d_stall = rst_n & d_miss & ~((state == DONE) & (grant == SIDE_D) & d_write_tag);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a pipelined memory model of fixed latency.
module tb_cache_mem_arbiter;

    localparam int unsigned AW    = 16;
    localparam int unsigned WORDS = 8;
    localparam int unsigned L     = 4;

    logic          clk;
    logic          rst_n;
    logic          i_miss, d_miss;
    logic [AW-1:0] i_miss_addr, d_miss_addr;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic          mem_data_valid;
    logic [AW-1:0] fill_addr;
    logic          i_fill_valid, d_fill_valid;
    logic          i_write_tag, d_write_tag;
    logic          i_stall, d_stall;
    logic          busy;
    logic          spur;
    logic [L-1:0]  pipe;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    cache_mem_arbiter #(.ADDR_W(AW), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_enable(mem_enable), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .fill_addr(fill_addr),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .i_write_tag(i_write_tag), .d_write_tag(d_write_tag),
        .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one issue per cycle, each returns exactly L cycles later.
    always @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[L-2:0], mem_enable};
    end
    assign mem_data_valid = pipe[L-1] | spur;

    task automatic step();
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic chk_all(input bit en, input logic [AW-1:0] addr, input logic [AW-1:0] fa,
                           input bit ifv, input bit dfv, input bit iwt, input bit dwt,
                           input bit ist, input bit dst, input bit bsy);
        chk("mem_enable",   32'(mem_enable),   32'(en));
        chk("mem_addr",     32'(mem_addr),     32'(addr));
        chk("fill_addr",    32'(fill_addr),    32'(fa));
        chk("i_fill_valid", 32'(i_fill_valid), 32'(ifv));
        chk("d_fill_valid", 32'(d_fill_valid), 32'(dfv));
        chk("i_write_tag",  32'(i_write_tag),  32'(iwt));
        chk("d_write_tag",  32'(d_write_tag),  32'(dwt));
        chk("i_stall",      32'(i_stall),      32'(ist));
        chk("d_stall",      32'(d_stall),      32'(dst));
        chk("busy",         32'(busy),         32'(bsy));
    endtask

    // Walks one block fill from its grant cycle (0) to the following IDLE cycle (14).
    // drop_at: cycle the owner lowers its miss (-1 = held); other_at: cycle the other side raises.
    task automatic do_fill(input bit is_d, input logic [AW-1:0] a, input int drop_at, input int other_at);
        logic [AW-1:0] base;
        logic [AW-1:0] e_addr, e_fa;
        bit            e_en, e_fv, e_wt, own_now, other_now;
        base = a & ~AW'(2 * WORDS - 1);
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) step();
            if (c == 0) begin
                if (is_d) begin d_miss = 1'b1; d_miss_addr = a; end
                else      begin i_miss = 1'b1; i_miss_addr = a; end
            end
            if (c == drop_at) begin
                if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
            end
            if (c == other_at) begin
                if (is_d) i_miss = 1'b1; else d_miss = 1'b1;
            end
            #1;
            e_en      = (c >= 1) && (c <= 8);
            e_addr    = e_en ? base + AW'(2 * (c - 1)) : '0;
            e_fv      = (c >= 5) && (c <= 12);
            e_fa      = e_fv ? base + AW'(2 * (c - 5)) : '0;
            own_now   = (drop_at < 0) || (c < drop_at);
            e_wt      = (c == 13) && own_now;
            other_now = (other_at >= 0) && (c >= other_at);
            if (is_d)
                chk_all(e_en, e_addr, e_fa, 1'b0, e_fv, 1'b0, e_wt,
                        other_now, own_now && !e_wt, c >= 1);
            else
                chk_all(e_en, e_addr, e_fa, e_fv, 1'b0, e_wt, 1'b0,
                        own_now && !e_wt, other_now, c >= 1);
        end
        step();
        if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; spur = 1'b0;
        i_miss = 1'b1; d_miss = 1'b1;
        i_miss_addr = 16'h8A1E; d_miss_addr = 16'h1234;

        // Reset held with both misses pending: everything quiet.
        repeat (3) step();
        #1;
        chk_all(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First tie after reset goes to D, then I is served without re-raising.
        step();
        rst_n = 1'b1;
        do_fill(1'b1, 16'h1234, -1, 0);
        do_fill(1'b0, 16'h8A1E, -1, -1);

        // Lone D miss with the reference timing.
        do_fill(1'b1, 16'h1234, -1, -1);

        // D arrives mid I fill: no preemption; D address sampled only at its own grant.
        d_miss_addr = 16'h7777;
        do_fill(1'b0, 16'h0F02, -1, 3);
        do_fill(1'b1, 16'hBEEF, -1, -1);

        // D miss abandoned mid fill: data still returns, tag never written.
        do_fill(1'b1, 16'h2468, 6, -1);
        chk("busy_after_abandon", 32'(busy), 32'd0);
        chk("mem_en_after_abandon", 32'(mem_enable), 32'd0);

        // Reset in the middle of a fill.
        step();
        d_miss = 1'b1; d_miss_addr = 16'h4000;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 7) rst_n = 1'b0;
        end
        #1;
        chk("mem_addr_pre_reset", 32'(mem_addr), 32'h400C);
        step();
        #1;
        chk_all(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Spurious return while IDLE routes nowhere.
        step();
        rst_n = 1'b1; d_miss = 1'b0; spur = 1'b1;
        #1;
        chk_all(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        spur = 1'b0;
        do_fill(1'b1, 16'h4A56, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
